// File: rtl/gbuff_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : gbuff_stream_reader
//  Description : Streams a contiguous (wrapping) range of BRAM words out on a
//                valid/ready interface through a 2-entry skid FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module gbuff_stream_reader #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_en,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] index,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_last
);

  localparam logic [ADDR_BITS:0] LEN_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q;
  logic [ADDR_BITS:0]   len_q;
  logic [ADDR_BITS:0]   iss_q;    // reads issued so far
  logic [ADDR_BITS:0]   hand_q;   // words handed downstream so far
  logic [ADDR_BITS-1:0] index_q;
  logic                 done_q;

  logic [DATA_BITS-1:0] fifo_data_q [2];
  logic                 fifo_last_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;

  logic                 pop;
  logic                 issue;
  logic                 issue_last;
  logic                 hand_last;
  logic [ADDR_BITS-1:0] rd_addr;

  // BRAM answers within the issue cycle, so the FIFO count alone bounds the
  // words outstanding; a same-cycle pop frees the slot the new word will use.
  always_comb begin
    pop        = (count_q != 2'd0) && out_ready;
    issue      = (state_q == S_READ) && (iss_q != len_q) &&
                 ((count_q != 2'd2) || pop);
    issue_last = issue && (iss_q == len_q - LEN_ONE);
    hand_last  = (state_q == S_DRAIN) && pop && (hand_q == len_q - LEN_ONE);
    rd_addr    = base_q + iss_q[ADDR_BITS-1:0];
  end

  // Next-state selection for the transfer sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && (length != '0)) state_d = S_READ;
      S_READ:  if (issue_last)              state_d = S_DRAIN;
      S_DRAIN: if (hand_last)               state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // Control registers: state, latched request, progress counters, FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      iss_q    <= '0;
      hand_q   <= '0;
      index_q  <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      done_q  <= ((state_q == S_IDLE) && start && (length == '0)) || hand_last;
      if ((state_q == S_IDLE) && start) begin
        base_q <= base_addr;
        len_q  <= length;
        iss_q  <= '0;
        hand_q <= '0;
      end else begin
        if (issue) iss_q  <= iss_q + LEN_ONE;
        if (pop)   hand_q <= hand_q + LEN_ONE;
      end
      if (issue) begin
        index_q  <= rd_addr;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({issue, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage: the word read in the issue cycle lands on the closing edge
  always_ff @(posedge clk) begin
    if (issue) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_last_q[wr_ptr_q] <= issue_last;
    end
  end

  // Output drive; data and last read as zero whenever the FIFO is empty
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    ram_en    = issue;
    wr_en     = 1'b0;
    index     = issue ? rd_addr : index_q;
    out_valid = (count_q != 2'd0);
    out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_last  = out_valid && fifo_last_q[rd_ptr_q];
  end

endmodule
`default_nettype wire

// File: doc/gbuff_stream_reader.md
GBUFF_STREAM_READER -- requirements
Module: gbuff_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, BRAM index width (2^ADDR_BITS entries).
REQ-002 SHALL have parameter DATA_BITS, default 32, BRAM word width.
REQ-003 SHALL have one clock and one reset: clk  input  1  sole clock, all logic on rising edge; rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin transfer; sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  ADDR_BITS  first BRAM index, latched on accepted start.
REQ-006 SHALL have port length  input  ADDR_BITS+1  word count 0..2^ADDR_BITS, latched on accepted start.
REQ-007 SHALL have port busy  output  1  high when not in IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port ram_en  output  1  BRAM enable, high only in read-issue cycles.
REQ-010 SHALL have port wr_en  output  1  BRAM write enable, constant 0.
REQ-011 SHALL have port index  output  ADDR_BITS  BRAM address.
REQ-012 SHALL have port rd_data  input  DATA_BITS  BRAM data_out (BRAM reads on falling edge).
REQ-013 SHALL have ports out_valid output 1, out_ready input 1, out_data output DATA_BITS, out_last output 1  downstream valid/ready stream.

Function
REQ-014 SHALL implement states IDLE, READ, DRAIN; IDLE->READ on start with length>0; READ->DRAIN when all length reads issued; DRAIN->IDLE when all words handed off.
REQ-015 SHALL, on start with length==0 in IDLE, stay in IDLE, issue no reads, and pulse done in the next cycle.
REQ-016 SHALL ignore start while busy; latched base_addr/length unchanged.
REQ-017 SHALL issue read k (k=0..length-1) with ram_en=1, index=(base_addr+k) mod 2^ADDR_BITS; wrap past top of BRAM is legal.
REQ-018 SHALL capture rd_data into a 2-entry output FIFO on the rising edge ending the issue cycle (1-cycle read latency).
REQ-019 SHALL issue a read only when FIFO occupancy + in-flight reads - (same-cycle pop) < 2; never overflow, never drop a word.
REQ-020 SHALL, with start in cycle N and out_ready held 1, assert ram_en in cycle N+1 and out_valid in cycle N+2, then sustain one word per cycle.
REQ-021 SHALL drive out_valid = FIFO non-empty, out_data = FIFO head; handoff on out_valid&out_ready.
REQ-022 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL assert out_last exactly with word length-1 of the transfer.
REQ-024 SHALL pulse done for one cycle in the cycle after the handshake of the last word; busy falls in that same cycle.
REQ-025 SHALL accept a new start in the cycle done is high (IDLE reached).
REQ-026 SHALL drive ram_en=0 and index at its last value when no read is issued.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, enter IDLE, empty FIFO, clear in-flight tracking; outputs busy=0, done=0, ram_en=0, wr_en=0, index=0, out_valid=0, out_last=0, out_data=0.
REQ-028 SHALL, on reset mid-transfer, discard all in-flight and buffered words and not pulse done.

Verification
REQ-029 SHALL cover: BRAM preloaded mem[i]=i+100, base_addr=5, length=4, out_ready=1 -> out_data 105,106,107,108 on consecutive cycles, out_last on 108, done one cycle later.
REQ-030 SHALL cover: ADDR_BITS=4, base_addr=14, length=4 -> index 14,15,0,1; data mem[14],mem[15],mem[0],mem[1].
REQ-031 SHALL cover: length=8, out_ready random 50% -> all 8 words in order, no loss/duplication, out_data stable during stalls, ram_en never high with FIFO+in-flight at 2.
REQ-032 SHALL cover: length=0 start -> no ram_en, no out_valid, done pulse next cycle, busy stays 0.
REQ-033 SHALL cover: rst asserted after 3 of 10 words delivered -> all outputs at reset values next cycle, no done; fresh start length=2 then completes correctly.
REQ-034 SHALL cover: start pulsed while busy with different base_addr -> ignored, original transfer completes unchanged.
